// File: rtl/cg_seq_pkg.sv
// Shared types and default timing for the CG phase sequencer.
package cg_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStartup,
    StMxv,
    StGap,
    StVxv,
    StCheck,
    StDone
  } seq_state_e;

  localparam int unsigned DefStartupCycles = 2;
  localparam int unsigned DefGapCycles     = 4;

endpackage

// File: rtl/seq_cycle_counter.sv
// Loadable down-counter that stops at zero; times STARTUP, GAP and the phase watchdog.
module seq_cycle_counter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/cg_phase_sequencer.sv
// Alternates the mXv / vXv unit resets, counts CG iterations and halts the solve.
// Defining CG_SEQ_TIMEOUT_EN adds a per-phase watchdog that forces DONE with timeout set.
module cg_phase_sequencer
  import cg_seq_pkg::*;
#(
  parameter int unsigned ITER_W         = 16,
  parameter int unsigned STARTUP_CYCLES = DefStartupCycles,
  parameter int unsigned GAP_CYCLES     = DefGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              mxv_finish,
  input  logic              vxv_finish,
  input  logic              converged,
  output logic              reset_mXv1,
  output logic              reset_vXv1,
  output logic              busy,
  output logic              halt,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned MaxSg  = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > MaxSg) ? TIMEOUT_CYCLES : MaxSg;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  seq_state_e        state_q, state_d;
  logic              gap_to_vxv_q, gap_to_vxv_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic [ITER_W-1:0] iter_d;
  logic              cnt_load, cnt_zero;
  logic [CntW-1:0]   cnt_val;
`ifdef CG_SEQ_TIMEOUT_EN
  logic              timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    gap_to_vxv_d = gap_to_vxv_q;
    limit_d      = limit_q;
    iter_d       = iter_count;
`ifdef CG_SEQ_TIMEOUT_EN
    timeout_d    = timeout;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          limit_d = max_iter;
          iter_d  = '0;
`ifdef CG_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = (max_iter == '0) ? StDone : StStartup;
        end
      end
      StStartup: if (cnt_zero) state_d = StMxv;
      StMxv: begin
        if (mxv_finish) begin
          state_d      = StGap;
          gap_to_vxv_d = 1'b1;
`ifdef CG_SEQ_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d   = StDone;
          timeout_d = 1'b1;
`endif
        end
      end
      StGap: if (cnt_zero) state_d = gap_to_vxv_q ? StVxv : StMxv;
      StVxv: begin
        if (vxv_finish) begin
          iter_d  = iter_count + ITER_W'(1);
          state_d = StCheck;
`ifdef CG_SEQ_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d   = StDone;
          timeout_d = 1'b1;
`endif
        end
      end
      StCheck: begin
        if (converged || (iter_count == limit_q)) begin
          state_d = StDone;
        end else begin
          state_d      = StGap;
          gap_to_vxv_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The counter is reloaded on every state change with the duration of the state being entered.
  always_comb begin
    cnt_load = (state_d != state_q);
    case (state_d)
      StStartup: cnt_val = CntW'(STARTUP_CYCLES - 1);
      StGap:     cnt_val = CntW'(GAP_CYCLES - 1);
`ifdef CG_SEQ_TIMEOUT_EN
      StMxv, StVxv: cnt_val = CntW'(TIMEOUT_CYCLES - 1);
`endif
      default:   cnt_val = '0;
    endcase
  end

  seq_cycle_counter #(
    .Width(CntW)
  ) u_cycle_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      gap_to_vxv_q <= 1'b0;
      limit_q      <= '0;
      iter_count   <= '0;
      reset_mXv1   <= 1'b1;
      reset_vXv1   <= 1'b1;
      busy         <= 1'b0;
      halt         <= 1'b0;
`ifdef CG_SEQ_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gap_to_vxv_q <= gap_to_vxv_d;
      limit_q      <= limit_d;
      iter_count   <= iter_d;
      reset_mXv1   <= (state_d != StMxv);
      reset_vXv1   <= (state_d != StVxv);
      busy         <= (state_d != StIdle) && (state_d != StDone);
      halt         <= (state_d == StDone);
`ifdef CG_SEQ_TIMEOUT_EN
      timeout      <= timeout_d;
`endif
    end
  end

`ifndef CG_SEQ_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule
